midi_msg_parser: RTL and testbench
==================================

Name: midi_msg_parser

Overview:
- Byte-level MIDI parser that sits between the UART receiver and the synth front end.
- Assembles 1/2-data-byte channel messages, with running status, from the received byte stream.
- Emits note events to the voice allocator.
- Emits control-change events on the `param_change_ready`/`note`/`velocity` interface consumed directly by the parameter updater.

Parameters:
- CHANNEL, 0, MIDI channel (0-15) accepted when FILTER_EN=1
- FILTER_EN, 1, 1 = drop channel messages not on CHANNEL; 0 = omni
- ERR_CNT_W, 8, width of saturating error counter

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- byte_valid  in  1  one-cycle strobe, byte_data valid
- byte_data  in  8  received MIDI byte
- byte_err  in  1  UART framing error, qualifies byte_valid
- note_valid  out  1  one-cycle pulse: note on/off event
- note_on  out  1  1 = note-on, 0 = note-off (valid with note_valid)
- param_change_ready  out  1  one-cycle pulse: control-change event
- note  out  7  note number (note event) or controller number (CC event)
- velocity  out  7  velocity (note event) or controller value (CC event)
- err_count  out  ERR_CNT_W  saturating count of aborted messages

Behaviour:
- Reset: all outputs 0; state = NO_STATUS; running status cleared.
- Byte classes:
  - data = bit7 0
  - channel status = 0x80-0xEF
  - system common = 0xF0-0xF7
  - real-time = 0xF8-0xFF
- Real-time bytes:
  - Ignored in every state.
  - No change to state, running status or the partially assembled message.
  - May arrive between data bytes of one message.
- Channel status byte:
  - Latch as running status; clear the pending data byte.
  - Go to WAIT_D1.
  - If it arrives while in WAIT_D2 (message incomplete): err_count += 1.
- System common byte:
  - Clear running status; go to NO_STATUS.
  - If it interrupts an incomplete message: err_count += 1.
  - SysEx data bytes are discarded while in NO_STATUS.
- States:
  - NO_STATUS: data bytes discarded.
  - WAIT_D1:
    - data byte -> latch d1.
    - If the message length is 1 (0xCn, 0xDn): message complete, consume, stay in WAIT_D1.
    - Else go to WAIT_D2.
  - WAIT_D2: data byte -> message complete; return to WAIT_D1 (running status retained).
- Complete message dispatch (outputs registered; pulse in the cycle after the completing byte's byte_valid):
  - 0x9n, d2 != 0 -> note_valid=1, note_on=1, note=d1, velocity=d2.
  - 0x9n, d2 == 0 -> note_valid=1, note_on=0, velocity=0.
  - 0x8n -> note_valid=1, note_on=0, velocity=d2 (release velocity passed through).
  - 0xBn -> param_change_ready=1, note=d1, velocity=d2.
  - 0xAn, 0xCn, 0xDn, 0xEn -> consumed silently, no pulse.
- Channel filter: FILTER_EN=1 and n != CHANNEL -> message parsed (state advances normally) but no pulse.
- Output holding:
  - note/velocity hold their last value between events.
  - note_valid and param_change_ready are never both 1.
  - Each pulse is exactly one cycle.
- byte_err=1 with byte_valid:
  - Byte discarded.
  - If in WAIT_D2: err_count += 1, return to WAIT_D1.
  - Running status kept.
- err_count saturates at 2^ERR_CNT_W-1; cleared only by reset.
- Back-to-back byte_valid on consecutive cycles must be accepted without loss (throughput 1 byte/cycle).
- Reset mid-message: the partial message is lost; no pulse emitted.

Decomposition:
- Shared package: `midi_state_t` enum {NO_STATUS, WAIT_D1, WAIT_D2}.
- Shared package: status-nibble constants MIDI_NOTE_OFF=4'h8, MIDI_NOTE_ON=4'h9, MIDI_POLY_AT=4'hA, MIDI_CC=4'hB, MIDI_PROG=4'hC, MIDI_CH_AT=4'hD, MIDI_PBEND=4'hE.
- Shared package: function `midi_data_len(nibble)` returning 1 or 2.
- One sub-module: `midi_byte_classifier`, combinational byte-to-class decode (data / channel / common / realtime).

Test Plan:
- CHANNEL=0: bytes 0x90,0x3C,0x64 -> one-cycle note_valid=1, note_on=1, note=0x3C, velocity=0x64 in the cycle after 0x64.
- Running status: 0x90,0x3C,0x64,0x3C,0x00 -> second event note_valid=1, note_on=0, note=0x3C, velocity=0.
- CC: 0xB0,0x18,0x40 -> param_change_ready=1, note=24, velocity=64, note_valid stays 0; then 0xB1,0x18,0x40 -> no pulse (filter).
- Real-time interleave: 0x90,0xF8,0x40,0xFE,0x7F -> single note-on, note=0x40, velocity=0x7F; err_count unchanged.
- Abort: 0x90,0x3C,0xB0,0x15,0x10 -> err_count=1; note event for 0x3C never emitted; param_change_ready with note=21, velocity=16.
- Program change: 0xC0,0x05,0x07 then 0x90,0x30,0x01 -> no pulses for the 0xC0 message; note-on note=0x30, velocity=1. Then assert rst_n=0 mid-stream after 0x90,0x30 -> no pulse; all outputs 0.

Source files
------------

// File: rtl/midi_msg_parser_pkg.sv
// Shared types and constants for the MIDI channel-message parser.
package midi_msg_parser_pkg;

  typedef enum logic [1:0] {
    NO_STATUS,
    WAIT_D1,
    WAIT_D2
  } midi_state_t;

  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;
  localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
  localparam logic [3:0] MIDI_POLY_AT  = 4'hA;
  localparam logic [3:0] MIDI_CC       = 4'hB;
  localparam logic [3:0] MIDI_PROG     = 4'hC;
  localparam logic [3:0] MIDI_CH_AT    = 4'hD;
  localparam logic [3:0] MIDI_PBEND    = 4'hE;

  // Number of data bytes following a channel status nibble.
  function automatic logic [1:0] midi_data_len(input logic [3:0] nibble);
    return (nibble == MIDI_PROG || nibble == MIDI_CH_AT) ? 2'd1 : 2'd2;
  endfunction

endpackage

// File: rtl/midi_msg_parser_byte_classifier.sv
// Combinational decode of a received MIDI byte into its class.
module midi_byte_classifier (
  input  logic [7:0] byte_data,
  output logic       is_data,
  output logic       is_channel,
  output logic       is_common,
  output logic       is_realtime
);

  assign is_data     = ~byte_data[7];
  assign is_channel  = byte_data[7] & (byte_data[6:4] != 3'b111);
  assign is_common   = (byte_data[7:3] == 5'b11110);
  assign is_realtime = (byte_data[7:3] == 5'b11111);

endmodule

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser: running-status channel messages to note / CC events.
module midi_msg_parser
  import midi_msg_parser_pkg::*;
#(
  parameter int unsigned CHANNEL   = 0,
  parameter bit          FILTER_EN = 1'b1,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 byte_valid,
  input  logic [7:0]           byte_data,
  input  logic                 byte_err,
  output logic                 note_valid,
  output logic                 note_on,
  output logic                 param_change_ready,
  output logic [6:0]           note,
  output logic [6:0]           velocity,
  output logic [ERR_CNT_W-1:0] err_count
);

  midi_state_t state, state_next;
  logic [7:0]  status;
  logic [6:0]  d1;
  logic        is_data, is_channel, is_common, is_realtime;
  logic        err_inc, d1_load, status_load, status_clear, complete;
  logic [6:0]  msg_d1;
  logic        chan_ok;

  midi_byte_classifier u_classifier (
    .byte_data   (byte_data),
    .is_data     (is_data),
    .is_channel  (is_channel),
    .is_common   (is_common),
    .is_realtime (is_realtime)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= NO_STATUS;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    err_inc      = 1'b0;
    d1_load      = 1'b0;
    status_load  = 1'b0;
    status_clear = 1'b0;
    complete     = 1'b0;
    if (byte_valid) begin
      if (byte_err) begin
        if (state == WAIT_D2) begin
          err_inc    = 1'b1;
          state_next = WAIT_D1;
        end
      end else if (is_realtime) begin
        state_next = state;
      end else if (is_channel) begin
        status_load = 1'b1;
        err_inc     = (state == WAIT_D2);
        state_next  = WAIT_D1;
      end else if (is_common) begin
        status_clear = 1'b1;
        err_inc      = (state == WAIT_D2);
        state_next   = NO_STATUS;
      end else if (is_data) begin
        case (state)
          WAIT_D1: begin
            d1_load = 1'b1;
            if (midi_data_len(status[7:4]) == 2'd1) complete   = 1'b1;
            else                                    state_next = WAIT_D2;
          end
          WAIT_D2: begin
            complete   = 1'b1;
            state_next = WAIT_D1;
          end
          default: ;
        endcase
      end
    end
  end

  // One-byte messages complete on the byte that would otherwise become d1.
  assign msg_d1  = (state == WAIT_D1) ? byte_data[6:0] : d1;
  assign chan_ok = !FILTER_EN || (status[3:0] == 4'(CHANNEL));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status             <= '0;
      d1                 <= '0;
      note_valid         <= 1'b0;
      note_on            <= 1'b0;
      param_change_ready <= 1'b0;
      note               <= '0;
      velocity           <= '0;
      err_count          <= '0;
    end else begin
      note_valid         <= 1'b0;
      param_change_ready <= 1'b0;
      if (status_load) begin
        status <= byte_data;
        d1     <= '0;
      end else if (status_clear) begin
        status <= '0;
      end
      if (d1_load) d1 <= byte_data[6:0];
      if (err_inc && err_count != '1) err_count <= err_count + ERR_CNT_W'(1);
      if (complete && chan_ok) begin
        case (status[7:4])
          MIDI_NOTE_ON: begin
            note_valid <= 1'b1;
            note_on    <= |byte_data[6:0];
            note       <= msg_d1;
            velocity   <= byte_data[6:0];
          end
          MIDI_NOTE_OFF: begin
            note_valid <= 1'b1;
            note_on    <= 1'b0;
            note       <= msg_d1;
            velocity   <= byte_data[6:0];
          end
          MIDI_CC: begin
            param_change_ready <= 1'b1;
            note               <= msg_d1;
            velocity           <= byte_data[6:0];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_midi_msg_parser.sv
// Randomized and directed checks of midi_msg_parser against a message-level model.
module tb_midi_msg_parser;

  localparam int unsigned ERR_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_err;
  logic             note_valid;
  logic             note_on;
  logic             param_change_ready;
  logic [6:0]       note;
  logic [6:0]       velocity;
  logic [ERR_W-1:0] err_count;

  midi_msg_parser #(
    .CHANNEL   (0),
    .FILTER_EN (1'b1),
    .ERR_CNT_W (ERR_W)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .byte_valid         (byte_valid),
    .byte_data          (byte_data),
    .byte_err           (byte_err),
    .note_valid         (note_valid),
    .note_on            (note_on),
    .param_change_ready (param_change_ready),
    .note               (note),
    .velocity           (velocity),
    .err_count          (err_count)
  );

  always #5 clk = ~clk;

  int unsigned tests_run = 0;
  int unsigned tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Message-level reference: running status byte plus a queue of collected data bytes.
  int         rs;
  int         q[$];
  logic       exp_nv, exp_on, exp_pcr;
  logic [6:0] exp_note, exp_vel;
  int         exp_err;

  task automatic model_reset();
    rs = -1;
    q.delete();
    exp_nv = 0; exp_on = 0; exp_pcr = 0;
    exp_note = 0; exp_vel = 0; exp_err = 0;
  endtask

  task automatic model_abort();
    if (q.size() > 0 && exp_err < (1 << ERR_W) - 1) exp_err++;
    q.delete();
  endtask

  task automatic model(input logic v, input logic [7:0] b, input logic e);
    int len, d1, d2, kind, chan;
    exp_nv  = 0;
    exp_pcr = 0;
    if (!v) return;
    if (e) begin
      model_abort();
      return;
    end
    if (b >= 8'hF8) return;
    if (b >= 8'hF0) begin
      model_abort();
      rs = -1;
      return;
    end
    if (b >= 8'h80) begin
      model_abort();
      rs = b;
      return;
    end
    if (rs < 0) return;
    q.push_back(int'(b));
    kind = rs / 16;
    chan = rs % 16;
    len  = (kind == 12 || kind == 13) ? 1 : 2;
    if (q.size() < len) return;
    d1 = q[0];
    d2 = (len == 2) ? q[1] : 0;
    q.delete();
    if (chan != 0) return;
    if (kind == 9 || kind == 8) begin
      exp_nv   = 1;
      exp_on   = (kind == 9) && (d2 != 0);
      exp_note = 7'(d1);
      exp_vel  = 7'(d2);
    end else if (kind == 11) begin
      exp_pcr  = 1;
      exp_note = 7'(d1);
      exp_vel  = 7'(d2);
    end
  endtask

  task automatic check_outputs();
    check_eq("note_valid", note_valid, exp_nv);
    check_eq("param_change_ready", param_change_ready, exp_pcr);
    check_eq("note", note, exp_note);
    check_eq("velocity", velocity, exp_vel);
    check_eq("err_count", err_count, exp_err);
    check_eq("pulse_exclusive", note_valid & param_change_ready, 0);
    if (exp_nv) check_eq("note_on", note_on, exp_on);
  endtask

  task automatic step(input logic v, input logic [7:0] b, input logic e);
    @(negedge clk);
    check_outputs();
    byte_valid = v;
    byte_data  = b;
    byte_err   = e;
    model(v, b, e);
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    byte_valid = 1'b0;
    byte_err   = 1'b0;
    model_reset();
    #1;
    check_eq("reset_note_valid", note_valid, 0);
    check_eq("reset_note_on", note_on, 0);
    check_eq("reset_pcr", param_change_ready, 0);
    check_eq("reset_note", note, 0);
    check_eq("reset_velocity", velocity, 0);
    check_eq("reset_err_count", err_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic random_byte();
    int unsigned sel;
    logic [7:0]  b;
    sel = $urandom_range(0, 99);
    if (sel < 45)      step(1'b1, 8'($urandom_range(0, 127)), 1'b0);
    else if (sel < 68) begin
      b = {4'($urandom_range(8, 14)), 4'($urandom_range(0, 3) == 0 ? 1 : 0)};
      step(1'b1, b, 1'b0);
    end
    else if (sel < 74) step(1'b1, 8'($urandom_range(8'hF0, 8'hF7)), 1'b0);
    else if (sel < 84) step(1'b1, 8'($urandom_range(8'hF8, 8'hFF)), 1'b0);
    else if (sel < 89) step(1'b1, 8'($urandom_range(0, 255)), 1'b1);
    else               idle();
  endtask

  initial begin
    rst_n      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    byte_err   = 1'b0;
    model_reset();
    do_reset();

    // Note-on, then running-status note-on with velocity 0.
    send(8'h90); send(8'h3C); send(8'h64); idle();
    send(8'h3C); send(8'h00); idle();

    // Control change on channel 0, then filtered on channel 1.
    send(8'hB0); send(8'h18); send(8'h40); idle();
    send(8'hB1); send(8'h18); send(8'h40); idle();

    // Real-time bytes between data bytes.
    send(8'h90); send(8'hF8); send(8'h40); send(8'hFE); send(8'h7F); idle();

    // Note-off with release velocity passed through.
    send(8'h80); send(8'h22); send(8'h33); idle();

    // Abort an incomplete note-on with a CC status.
    do_reset();
    send(8'h90); send(8'h3C); send(8'hB0); send(8'h15); send(8'h10); idle();
    check_eq("abort_err_count", err_count, 1);
    check_eq("abort_cc_note", note, 21);

    // Framing error and system-common abort.
    send(8'h90); send(8'h11); step(1'b1, 8'h22, 1'b1); send(8'h12); send(8'h13); idle();
    send(8'h90); send(8'h11); send(8'hF0); send(8'h12); send(8'h13); idle();

    // Program change is silent; then note-on; then reset mid-message.
    send(8'hC0); send(8'h05); send(8'h07); send(8'h90); send(8'h30); send(8'h01); idle();
    send(8'h90); send(8'h30);
    do_reset();
    send(8'h64); idle(); idle();

    // Saturation of the narrow error counter.
    for (int i = 0; i < 10; i++) begin
      send(8'h90); send(8'h01); send(8'h80);
    end
    idle();
    check_eq("err_saturated", err_count, (1 << ERR_W) - 1);

    do_reset();
    for (int i = 0; i < 3000; i++) random_byte();
    idle(); idle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
